gpr_wb_sched: RTL



---
 rtl/gpr_pkg.sv | 23 ++
 rtl/gpr_wb_sched_if.sv | 34 +++
 rtl/rr_arbiter.sv | 54 +++++
 rtl/gpr_wb_sched.sv | 130 +++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// ---------------------------------------------------------------
// gpr_pkg : shared constants and types for the GPR writeback path
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package gpr_pkg;

  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int NUM_GPR = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;
  localparam logic [AW-1:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] wd;
  } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/gpr_wb_sched_if.sv
// ---------------------------------------------------------------
// gpr_wb_sched_if : writeback requester bundle (valid/ready + rd/wd)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface gpr_wb_sched_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_wd;

  modport master (
    output req_valid,
    output req_rd,
    output req_wd,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_wd,
    output req_ready
  );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------
// rr_arbiter : round-robin arbiter, search starts one past the last grant
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic          found;

  // Two passes: indices above the pointer first, then wrap to the rest.
  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && (i > int'(ptr)) && req[PW'(i)]) begin
        grant[PW'(i)] = 1'b1;
        grant_idx     = PW'(i);
        found         = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && (i <= int'(ptr)) && req[PW'(i)]) begin
        grant[PW'(i)] = 1'b1;
        grant_idx     = PW'(i);
        found         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PW'(N - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gpr_wb_sched.sv
// ---------------------------------------------------------------
// gpr_wb_sched : writeback scheduler + GPR scoreboard; option GPR_WB_BYPASS_EN
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module gpr_wb_sched
  import gpr_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = gpr_pkg::AW,
  parameter int DW   = gpr_pkg::DW
) (
  input  logic                 clk,
  input  logic                 rst,
  gpr_wb_sched_if.slave        bus,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic [AW-1:0]        rs,
  input  logic [AW-1:0]        rt,
  output logic                 haz_a,
  output logic                 haz_b,
  output logic                 haz_d,
  output logic                 wb_we,
  output logic [AW-1:0]        wb_rd,
  output logic [DW-1:0]        wb_wd,
  output logic [NUM_GPR-1:0]   busy_vec,
  output logic                 fwd_a_valid,
  output logic                 fwd_b_valid,
  output logic [DW-1:0]        fwd_data
);

  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    ready;
  logic               xfer;
  wb_req_t            win;
  wb_req_t            win_chain [NREQ+1];
  logic [NUM_GPR-1:0] busy_q;
  logic [NUM_GPR-1:0] busy_nxt;
  logic               raw_a;
  logic               raw_b;

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (xfer),
    .grant   (grant)
  );

  assign ready         = rst ? '0 : grant;
  assign bus.req_ready = ready;
  assign xfer          = |ready;

  // Grant is one-hot, so a select chain acts as a plain mux.
  assign win_chain[0] = '0;
  for (genvar i = 0; i < NREQ; i++) begin : g_win
    assign win_chain[i+1] = ready[i] ? {bus.req_rd[i*AW +: AW], bus.req_wd[i*DW +: DW]}
                                     : win_chain[i];
  end
  assign win = win_chain[NREQ];

  // Writes to r0 are accepted from the requester but never reach the file.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we <= 1'b0;
      wb_rd <= '0;
      wb_wd <= '0;
    end else begin
      wb_we <= xfer && (win.rd != REG_ZERO);
      if (xfer) begin
        wb_rd <= win.rd;
        wb_wd <= win.wd;
      end
    end
  end

  // Clear before set so a new producer wins over the retiring one.
  always_comb begin
    busy_nxt = busy_q;
    if (wb_we) begin
      busy_nxt[wb_rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != REG_ZERO)) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;
  assign raw_a    = busy_q[rs] && (rs != REG_ZERO);
  assign raw_b    = busy_q[rt] && (rt != REG_ZERO);
  assign haz_d    = busy_q[iss_rd] && (iss_rd != REG_ZERO);

`ifdef GPR_WB_BYPASS_EN
  assign fwd_a_valid = wb_we && (rs == wb_rd) && (rs != REG_ZERO);
  assign fwd_b_valid = wb_we && (rt == wb_rd) && (rt != REG_ZERO);
  assign fwd_data    = wb_wd;
`else
  assign fwd_a_valid = 1'b0;
  assign fwd_b_valid = 1'b0;
  assign fwd_data    = '0;
`endif

  assign haz_a = raw_a && !fwd_a_valid;
  assign haz_b = raw_b && !fwd_b_valid;

  for (genvar i = 0; i < NREQ; i++) begin : g_hold_chk
    a_valid_hold: assert property (@(posedge clk) disable iff (rst)
      (bus.req_valid[i] && !bus.req_ready[i]) |=> bus.req_valid[i]);
  end

  // Re-issuing to a register whose producer commits on this same edge is legal.
  a_issue_busy: assert property (@(posedge clk) disable iff (rst)
    (iss_valid && (iss_rd != REG_ZERO) && !(wb_we && (wb_rd == iss_rd)))
      |-> !busy_q[iss_rd]);

endmodule

`default_nettype wire
